// File: rtl/r2sdf_stage_if.sv
// Sample, flush, twiddle-ROM and output signals of one radix-2 SDF stage.
// Output width follows R2SDF_SCALE_EN: DW when defined, DW+1 otherwise.
interface r2sdf_stage_if #(
  parameter int DW = 16,
  parameter int TW = 16,
  parameter int AW = 10
);
`ifdef R2SDF_SCALE_EN
  localparam int OW = DW;
`else
  localparam int OW = DW + 1;
`endif

  logic                 iData_valid;
  logic signed [DW-1:0] iData_Re;
  logic signed [DW-1:0] iData_Im;
  logic                 iFlush;
  logic        [AW-1:0] oTw_Addr;
  logic signed [TW-1:0] iTw_Re;
  logic signed [TW-1:0] iTw_Im;
  logic                 oData_valid;
  logic signed [OW-1:0] oData_Re;
  logic signed [OW-1:0] oData_Im;
  logic                 oBusy;

  modport slave (
    input  iData_valid, iData_Re, iData_Im, iFlush, iTw_Re, iTw_Im,
    output oTw_Addr, oData_valid, oData_Re, oData_Im, oBusy
  );

  modport master (
    output iData_valid, iData_Re, iData_Im, iFlush, iTw_Re, iTw_Im,
    input  oTw_Addr, oData_valid, oData_Re, oData_Im, oBusy
  );
endinterface

// File: rtl/r2sdf_stage.sv
// Radix-2 single-path delay-feedback FFT stage with twiddle multiply.
// R2SDF_SCALE_EN: halve butterfly results (round half-up) and keep DW-bit outputs.
//
// state | meaning
// IDLE  | no frame in flight, k = 0
// FILL  | storing first half of the first frame
// BFLY  | second half arriving: emit a+b, store a-b
// SHIFT | emit stored difference x twiddle, store next frame's first half
// DRAIN | flushing stored differences x twiddle without input
module r2sdf_stage #(
  parameter int DW        = 16,
  parameter int DEPTH     = 16,
  parameter int TW        = 16,
  parameter int TW_STRIDE = 1,
  parameter int AW        = 10
) (
  input  logic           iClk,
  input  logic           iRst_n,
  r2sdf_stage_if.slave   bus
);
`ifdef R2SDF_SCALE_EN
  localparam int OW = DW;
`else
  localparam int OW = DW + 1;
`endif
  localparam int KW = $clog2(DEPTH);
  localparam int SW = DW + 2;
  localparam int PW = OW + TW + 1;
  localparam logic signed [PW-1:0] RND     = PW'(1) <<< (TW - 2);
  localparam logic signed [PW-1:0] SAT_MAX = (PW'(1) <<< (OW - 1)) - PW'(1);
  localparam logic signed [PW-1:0] SAT_MIN = -(PW'(1) <<< (OW - 1));

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_BFLY, S_SHIFT, S_DRAIN} state_t;

  state_t               state_q;
  logic        [KW-1:0] k_q;
  logic                 vld_q;
  logic signed [OW-1:0] re_q, im_q;
  logic signed [OW-1:0] dl_re_q [DEPTH];
  logic signed [OW-1:0] dl_im_q [DEPTH];

  logic                 advance, k_wrap, wr_en;
  logic        [KW-1:0] k_inc;
  logic signed [OW-1:0] head_re, head_im, in_re, in_im;
  logic signed [OW-1:0] sum_re, sum_im, dif_re, dif_im, wr_re, wr_im;
  logic signed [OW-1:0] tw_re, tw_im;
  logic signed [PW-1:0] acc_re, acc_im;

  function automatic logic signed [OW-1:0] bfly(input logic signed [OW-1:0] a,
                                                input logic signed [DW-1:0] b,
                                                input logic sub);
    logic signed [SW-1:0] s;
    s = sub ? (SW'(a) - SW'(b)) : (SW'(a) + SW'(b));
`ifdef R2SDF_SCALE_EN
    s = (s + SW'(signed'(2'sb01))) >>> 1;
`endif
    return OW'(s);
  endfunction

  function automatic logic signed [OW-1:0] round_sat(input logic signed [PW-1:0] acc);
    logic signed [PW-1:0] r;
    r = (acc + RND) >>> (TW - 1);
    if (r > SAT_MAX)      r = SAT_MAX;
    else if (r < SAT_MIN) r = SAT_MIN;
    return OW'(r);
  endfunction

  // DRAIN runs without input; every other state waits for a sample
  assign advance = (state_q == S_DRAIN) || bus.iData_valid;
  assign k_wrap  = (k_q == KW'(DEPTH - 1));
  assign k_inc   = k_q + KW'(1);

  // Circular buffer addressed by k: entry k was written exactly DEPTH advances ago
  assign head_re = dl_re_q[k_q];
  assign head_im = dl_im_q[k_q];
  assign in_re   = OW'(bus.iData_Re);
  assign in_im   = OW'(bus.iData_Im);

  assign sum_re = bfly(head_re, bus.iData_Re, 1'b0);
  assign sum_im = bfly(head_im, bus.iData_Im, 1'b0);
  assign dif_re = bfly(head_re, bus.iData_Re, 1'b1);
  assign dif_im = bfly(head_im, bus.iData_Im, 1'b1);

  assign acc_re = PW'(head_re) * PW'(bus.iTw_Re) - PW'(head_im) * PW'(bus.iTw_Im);
  assign acc_im = PW'(head_re) * PW'(bus.iTw_Im) + PW'(head_im) * PW'(bus.iTw_Re);
  assign tw_re  = round_sat(acc_re);
  assign tw_im  = round_sat(acc_im);

  assign wr_en = advance && (state_q != S_DRAIN);
  assign wr_re = (state_q == S_BFLY) ? dif_re : in_re;
  assign wr_im = (state_q == S_BFLY) ? dif_im : in_im;

  always_ff @(posedge iClk) begin
    if (wr_en) begin
      dl_re_q[k_q] <= wr_re;
      dl_im_q[k_q] <= wr_im;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      vld_q   <= 1'b0;
      re_q    <= '0;
      im_q    <= '0;
    end else begin
      vld_q <= 1'b0;
      if (advance) k_q <= k_inc;
      case (state_q)
        S_IDLE: if (advance) state_q <= S_FILL;
        S_FILL: if (advance && k_wrap) state_q <= S_BFLY;
        S_BFLY: if (advance) begin
          vld_q <= 1'b1;
          re_q  <= sum_re;
          im_q  <= sum_im;
          if (k_wrap) state_q <= bus.iFlush ? S_DRAIN : S_SHIFT;
        end
        S_SHIFT: begin
          if (advance) begin
            vld_q <= 1'b1;
            re_q  <= tw_re;
            im_q  <= tw_im;
            // flush on the last difference: nothing left to drain
            if (k_wrap)           state_q <= bus.iFlush ? S_IDLE : S_BFLY;
            else if (bus.iFlush)  state_q <= S_DRAIN;
          end else if (bus.iFlush) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          vld_q <= 1'b1;
          re_q  <= tw_re;
          im_q  <= tw_im;
          if (k_wrap) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.oTw_Addr    = (state_q == S_SHIFT || state_q == S_DRAIN)
                           ? AW'(k_q) * AW'(TW_STRIDE) : '0;
  assign bus.oData_valid = vld_q;
  assign bus.oData_Re    = re_q;
  assign bus.oData_Im    = im_q;
  assign bus.oBusy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_r2sdf_stage.sv
// Scoreboard bench for r2sdf_stage (DEPTH=4): frame-level model pushes
// expected outputs with their cycle stamp, a negedge monitor pops and compares.
module tb_r2sdf_stage;
  localparam int DW = 16, DEPTH = 4, TW = 16, AW = 10, STRIDE = 1;
`ifdef R2SDF_SCALE_EN
  localparam int OW = DW;
`else
  localparam int OW = DW + 1;
`endif
  localparam longint OMAX = (longint'(1) <<< (OW - 1)) - 1;
  localparam longint OMIN = -(longint'(1) <<< (OW - 1));

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  r2sdf_stage_if #(.DW(DW), .TW(TW), .AW(AW)) sif ();

  logic signed [TW-1:0] rom_re [1 << AW];
  logic signed [TW-1:0] rom_im [1 << AW];
  assign sif.iTw_Re = rom_re[sif.oTw_Addr];
  assign sif.iTw_Im = rom_im[sif.oTw_Addr];

  r2sdf_stage #(.DW(DW), .DEPTH(DEPTH), .TW(TW), .TW_STRIDE(STRIDE), .AW(AW)) dut (
    .iClk   (clk),
    .iRst_n (rst_n),
    .bus    (sif)
  );

  typedef struct {int re; int im; int cyc;} exp_t;
  exp_t expq[$];
  int   got_re[$], got_im[$];
  int   n_chk = 0, n_fail = 0;

  task automatic chk(string nm, longint act, longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  int fr_re[DEPTH], fr_im[DEPTH], df_re[DEPTH], df_im[DEPTH];
  int cnt = 0;
  bit fresh = 1'b1;

  function automatic int bf(int a, int b, bit sub);
    int s;
    s = sub ? a - b : a + b;
`ifdef R2SDF_SCALE_EN
    s = (s + 1) >>> 1;
`endif
    return s;
  endfunction

  function automatic int sat(longint v);
    if (v > OMAX) return int'(OMAX);
    if (v < OMIN) return int'(OMIN);
    return int'(v);
  endfunction

  task automatic push(int re, int im, int c);
    exp_t e;
    e.re = re; e.im = im; e.cyc = c;
    expq.push_back(e);
  endtask

  task automatic push_tw(int j, int c);
    int addr;
    longint wr, wi, pr, pi;
    addr = (j * STRIDE) % (1 << AW);
    wr = longint'(rom_re[addr]);
    wi = longint'(rom_im[addr]);
    pr = longint'(df_re[j]) * wr - longint'(df_im[j]) * wi;
    pi = longint'(df_re[j]) * wi + longint'(df_im[j]) * wr;
    push(sat((pr + (longint'(1) <<< (TW - 2))) >>> (TW - 1)),
         sat((pi + (longint'(1) <<< (TW - 2))) >>> (TW - 1)), c);
  endtask

  task automatic model_sample(int re, int im, bit flush, int m);
    int j;
    if (cnt < DEPTH) begin
      if (!fresh) push_tw(cnt, m + 1);
      fr_re[cnt] = re; fr_im[cnt] = im;
      cnt++;
    end else begin
      j = cnt - DEPTH;
      push(bf(fr_re[j], re, 1'b0), bf(fr_im[j], im, 1'b0), m + 1);
      df_re[j] = bf(fr_re[j], re, 1'b1);
      df_im[j] = bf(fr_im[j], im, 1'b1);
      cnt++;
      if (cnt == 2 * DEPTH) begin
        cnt = 0;
        fresh = 1'b0;
        if (flush) begin
          for (int i = 0; i < DEPTH; i++) push_tw(i, m + 2 + i);
          fresh = 1'b1;
        end
      end
    end
  endtask

  task automatic model_flush(int m);
    if (!fresh && cnt < DEPTH) begin
      for (int i = cnt; i < DEPTH; i++) push_tw(i, m + 2 + (i - cnt));
      fresh = 1'b1;
      cnt = 0;
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n && sif.oData_valid) begin
      got_re.push_back(int'(sif.oData_Re));
      got_im.push_back(int'(sif.oData_Im));
      if (expq.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("out_re", longint'(sif.oData_Re), e.re);
        chk("out_im", longint'(sif.oData_Im), e.im);
        chk("out_cycle", cyc, e.cyc);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(int re, int im, bit flush);
    sif.iData_valid = 1'b1;
    sif.iData_Re    = DW'(re);
    sif.iData_Im    = DW'(im);
    sif.iFlush      = flush;
    model_sample(re, im, flush, cyc);
    step();
    sif.iData_valid = 1'b0;
    sif.iFlush      = 1'b0;
  endtask

  task automatic flush_only();
    sif.iFlush = 1'b1;
    model_flush(cyc);
    step();
    sif.iFlush = 1'b0;
  endtask

  task automatic wait_empty(string nm);
    int t;
    t = 0;
    while (expq.size() > 0 && t < 100) begin
      step();
      t++;
    end
    chk(nm, expq.size(), 0);
    step();
  endtask

  task automatic set_rom_const(int re, int im);
    for (int i = 0; i < (1 << AW); i++) begin
      rom_re[i] = TW'(re);
      rom_im[i] = TW'(im);
    end
  endtask

  task automatic chk_got8(string nm, int ere[8], int eim[8]);
    chk({nm, "_count"}, got_re.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < got_re.size()) begin
        chk({nm, "_re"}, got_re[i], ere[i]);
        chk({nm, "_im"}, got_im[i], eim[i]);
      end
    end
  endtask

  int e035_re[8] = '{4, 6, 8, 10, -4, -4, -4, -4};
  int e035_im[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
  int e036_re[8] = '{4, 6, 8, 10, 0, 0, 0, 0};
  int e036_im[8] = '{0, 0, 0, 0, 4, 4, 4, 4};
  int e038_re[8] = '{-1, 0, 0, 0, 65535, 0, 0, 0};
  int e038_im[8] = '{-1, 0, 0, 0, 0, 0, 0, 0};

  initial begin
    sif.iData_valid = 1'b0;
    sif.iData_Re    = '0;
    sif.iData_Im    = '0;
    sif.iFlush      = 1'b0;
    set_rom_const(32767, 0);

    #3;
    chk("rst_valid", sif.oData_valid, 0);
    chk("rst_re", sif.oData_Re, 0);
    chk("rst_im", sif.oData_Im, 0);
    chk("rst_addr", sif.oTw_Addr, 0);
    chk("rst_busy", sif.oBusy, 0);
    #10 rst_n = 1'b1;
    step();

    // ramp 0..7, unity twiddle, flush at the BFLY->SHIFT transition
    got_re.delete(); got_im.delete();
    for (int i = 0; i < 8; i++) begin
      if (i == 4) chk("bfly_addr", sif.oTw_Addr, 0);
      send(i, 0, i == 7);
    end
    for (int j = 0; j < DEPTH; j++) begin
      chk("drain_addr", sif.oTw_Addr, j);
      chk("drain_busy", sif.oBusy, 1);
      step();
    end
    chk("idle_busy", sif.oBusy, 0);
    chk("idle_addr", sif.oTw_Addr, 0);
    wait_empty("ramp_pending");
`ifndef R2SDF_SCALE_EN
    chk_got8("ramp_unity", e035_re, e035_im);
`endif

    // twiddle -j
    set_rom_const(0, -32768);
    got_re.delete(); got_im.delete();
    for (int i = 0; i < 8; i++) send(i, 0, i == 7);
    wait_empty("ramp_mj_pending");
`ifndef R2SDF_SCALE_EN
    chk_got8("ramp_mj", e036_re, e036_im);
`endif

    // input stall after sample 5
    set_rom_const(32767, 0);
    got_re.delete(); got_im.delete();
    for (int i = 0; i < 8; i++) begin
      send(i, 0, i == 7);
      if (i == 5) repeat (3) step();
    end
    wait_empty("gap_pending");
`ifndef R2SDF_SCALE_EN
    chk_got8("gap", e035_re, e035_im);
`endif

    // full-scale difference saturating in the twiddle product
    set_rom_const(23170, -23170);
    got_re.delete(); got_im.delete();
    send(32767, 32767, 0);
    for (int i = 0; i < 3; i++) send(0, 0, 0);
    send(-32768, -32768, 0);
    for (int i = 0; i < 3; i++) send(0, 0, i == 2);
    wait_empty("sat_pending");
`ifndef R2SDF_SCALE_EN
    chk_got8("sat", e038_re, e038_im);
`endif

    // random twiddles and data, three frames with random stalls
    for (int i = 0; i < (1 << AW); i++) begin
      rom_re[i] = TW'(int'($urandom_range(0, 65535)) - 32768);
      rom_im[i] = TW'(int'($urandom_range(0, 65535)) - 32768);
    end
    for (int i = 0; i < 3 * 2 * DEPTH; i++) begin
      send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
           i == 3 * 2 * DEPTH - 1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) step();
    end
    wait_empty("rand_pending");

    // random data, standalone flush partway into the next frame
    for (int i = 0; i < 2 * 2 * DEPTH + 2; i++)
      send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768, 0);
    step();
    flush_only();
    wait_empty("partial_pending");
    chk("partial_idle_busy", sif.oBusy, 0);

    // reset while in SHIFT
    set_rom_const(32767, 0);
    for (int i = 0; i < 2 * DEPTH + 2; i++) send(i + 1, 3, 0);
    #6;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", sif.oData_valid, 0);
    chk("midrst_re", sif.oData_Re, 0);
    chk("midrst_im", sif.oData_Im, 0);
    chk("midrst_addr", sif.oTw_Addr, 0);
    chk("midrst_busy", sif.oBusy, 0);
    expq.delete();
    fresh = 1'b1;
    cnt = 0;
    #1 rst_n = 1'b1;
    step();
    send(9, 1, 0);
    chk("after_rst_busy", sif.oBusy, 1);
    for (int i = 1; i < 2 * DEPTH; i++) send(9 - i, i, i == 2 * DEPTH - 1);
    wait_empty("after_rst_pending");

`ifdef R2SDF_SCALE_EN
    got_re.delete(); got_im.delete();
    send(1, 0, 0);
    for (int i = 0; i < 3; i++) send(0, 0, 0);
    send(2, 0, 0);
    for (int i = 0; i < 3; i++) send(0, 0, i == 2);
    wait_empty("scale_pending");
    chk("scale_count", got_re.size(), 8);
    if (got_re.size() > 0) chk("scale_sum", got_re[0], 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/r2sdf_stage.md
R2SDF_STAGE -- requirements
Module: r2sdf_stage

Interface
REQ-001 SHALL have parameter DW, 16, input component width (two's complement).
REQ-002 SHALL have parameter DEPTH, 16, feedback delay length; power of two, 2..1024.
REQ-003 SHALL have parameter TW, 16, twiddle component width (Q1.(TW-1)).
REQ-004 SHALL have parameter TW_STRIDE, 1, twiddle address step per sample; power of two.
REQ-005 SHALL have parameter AW, 10, twiddle address width.
REQ-006 iClk  in  1  sole clock; all state on rising edge.
REQ-007 iRst_n  in  1  asynchronous, active-low reset.
REQ-008 iData_valid  in  1  input sample strobe.
REQ-009 iData_Re / iData_Im  in  DW each  input sample.
REQ-010 iFlush  in  1  single-cycle pulse; drain stored differences without a following frame.
REQ-011 oTw_Addr  out  AW  twiddle ROM address, combinational from state.
REQ-012 iTw_Re / iTw_Im  in  TW each  twiddle for oTw_Addr, same cycle (combinational ROM).
REQ-013 oData_valid  out  1  output sample strobe.
REQ-014 oData_Re / oData_Im  out  OW each  output; OW = DW+1, or DW with R2SDF_SCALE_EN.
REQ-015 oBusy  out  1  high in any state other than IDLE.

Function
REQ-016 SHALL hold a DEPTH-entry complex delay line of OW-bit entries and a log2(DEPTH)-bit sample counter k.
REQ-017 SHALL implement FSM IDLE, FILL, BFLY, SHIFT, DRAIN.
REQ-018 Advance (k increment, delay-line shift) SHALL occur on iData_valid=1 in IDLE/FILL/BFLY/SHIFT, and every cycle in DRAIN; no advance otherwise (stall, all state frozen).
REQ-019 IDLE: first advance writes sample into delay line, k=1, goes to FILL.
REQ-020 FILL: input sign-extended to OW written into delay line; no output; k wrap -> BFLY.
REQ-021 BFLY: with a = delay-line head, b = input: output a+b, write a-b into delay line; k wrap -> SHIFT.
REQ-022 SHIFT: output head x twiddle; input written into delay line (next frame's first half); k wrap -> BFLY.
REQ-023 iFlush in SHIFT, or at the BFLY->SHIFT transition, SHALL select DRAIN instead of waiting for input; DRAIN emits head x twiddle at remaining k each cycle, then IDLE; iFlush ignored in IDLE/FILL/DRAIN.
REQ-024 oTw_Addr SHALL equal k*TW_STRIDE in SHIFT/DRAIN, 0 otherwise.
REQ-025 Twiddle product SHALL be full-precision complex multiply, rounded half-up, shifted right by TW-1, saturated to OW bits.
REQ-026 Butterfly sum/difference SHALL be computed at OW bits without overflow.
REQ-027 Outputs SHALL be registered: latency exactly one iClk from the advancing input edge to oData_valid/oData_*.
REQ-028 oData_valid SHALL be high one cycle per advance in BFLY, SHIFT or DRAIN, low otherwise; oData_* hold last value when invalid.
REQ-029 Continuous input SHALL yield gap-free output after the first DEPTH-sample fill.

Reset
REQ-030 iRst_n low SHALL force IDLE, k=0, oData_valid=0, oData_Re=oData_Im=0, oTw_Addr=0, oBusy=0, asynchronously.
REQ-031 Delay-line contents need not be reset; reset mid-frame or mid-DRAIN discards the frame with no further output.

Configuration
REQ-032 Macro R2SDF_SCALE_EN defined: OW=DW; sum and difference SHALL be computed at DW+1 then arithmetically shifted right 1 with round-half-up before output/storage.
REQ-033 Macro R2SDF_SCALE_EN undefined: OW=DW+1, no scaling; all other behaviour identical.

Verification (DEPTH=4, DW=16, TW=16, TW_STRIDE=1, scaling off unless stated)
REQ-034 Reset asserted mid-SHIFT -> outputs 0, oBusy=0 within same cycle; next valid input starts FILL, no output for 4 samples.
REQ-035 Re=0..7, Im=0 continuous, ROM returns (32767,0) -> BFLY outputs Re 4,6,8,10, then (after iFlush) DRAIN outputs Re -4 x4, Im 0, oTw_Addr 0,1,2,3.
REQ-036 Same stream, ROM returns (0,-32768) -> DRAIN outputs (0,4) x4.
REQ-037 Same stream with iData_valid low 3 cycles after sample 5 -> identical output sequence, oData_valid gaps match input gaps, latency 1.
REQ-038 a=(32767,32767), b=(-32768,-32768), ROM (23170,-23170) -> difference (65535,65535); twiddled Re saturates to 65535.
REQ-039 R2SDF_SCALE_EN defined, inputs Re=1 and 2 paired -> sum output 2 (3/2 rounded half-up), 16-bit output port.
